// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 state encoding, command bytes and frame helper.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      REQ,
      SHIFT,
      ACK,
      RELEASE
   } ps2_state_e;

   localparam logic [7:0] CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] CMD_RESET    = 8'hFF;
   localparam logic [7:0] CMD_ENABLE   = 8'hF4;
   localparam logic [7:0] RESP_ACK     = 8'hFA;

   localparam int FRAME_BITS = 10;

   // {stop, odd parity, data}; start bit is driven separately by the request.
   function automatic logic [FRAME_BITS-1:0] ps2_frame(input logic [7:0] d);
      return {1'b1, ~^d, d};
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-FF synchronizer, FILTER_LEN-sample glitch filter and
// registered falling-edge flag for one PS/2 line (FILTER_LEN >= 2).
module ps2_line_filter #(
   parameter int FILTER_LEN = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic fall
);

   logic                  sync_q, sync_d;
   logic [FILTER_LEN-1:0] hist_q, hist_d;
   logic                  level_q, level_d;
   logic                  fall_q, fall_d;

   // hist_q[0] is the second synchronizer stage; the window spans FILTER_LEN samples.
   always_comb begin
      sync_d  = din;
      hist_d  = {hist_q[FILTER_LEN-2:0], sync_q};
      level_d = (&hist_q) ? 1'b1 : (~|hist_q) ? 1'b0 : level_q;
      fall_d  = level_q & ~level_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q  <= 1'b1;
         hist_q  <= '1;
         level_q <= 1'b1;
         fall_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         hist_q  <= hist_d;
         level_q <= level_d;
         fall_q  <= fall_d;
      end
   end

   assign level = level_q;
   assign fall  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter; inhibits the bus, requests to
// send, shifts a frame out on device clock falls and checks the ack bit.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 600,
   parameter int TIMEOUT_CYCLES = 75000,
   parameter int FILTER_LEN     = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       busy,
   output logic       done,
   output logic       ack_err,
   output logic       timeout
);

   localparam int             IW       = $clog2(INHIBIT_CYCLES + 1);
   localparam logic [IW-1:0]  INH_LAST = IW'(INHIBIT_CYCLES - 1);
   localparam logic [IW-1:0]  INH_END  = IW'(INHIBIT_CYCLES);
   localparam logic [16:0]    TMO_LAST = 17'(TIMEOUT_CYCLES - 1);

   ps2_state_e            state_q, state_d;
   logic [FRAME_BITS-1:0] frame_q, frame_d;
   logic [3:0]            bit_q, bit_d, bit_inc;
   logic [IW-1:0]         inh_q, inh_d;
   logic [16:0]           tmo_q, tmo_d;
   logic                  clk_oe_q, clk_oe_d;
   logic                  data_oe_q, data_oe_d;
   logic                  ready_q, ready_d;
   logic                  err_q, err_d;
   logic                  done_q, done_d;
   logic                  ack_err_q, ack_err_d;
   logic                  timeout_q, timeout_d;
   logic                  tmo_run;
   logic                  clk_lvl, clk_fall, data_lvl, data_fall_unused;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
      .clk   (clk),
      .rst   (rst),
      .din   (ps2_clk_in),
      .level (clk_lvl),
      .fall  (clk_fall)
   );

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
      .clk   (clk),
      .rst   (rst),
      .din   (ps2_data_in),
      .level (data_lvl),
      .fall  (data_fall_unused)
   );

   assign bit_inc = (bit_q == 4'd11) ? bit_q : bit_q + 4'd1;
   assign tmo_run = state_q inside {REQ, SHIFT, ACK, RELEASE};

   always_comb begin
      state_d   = state_q;
      frame_d   = frame_q;
      bit_d     = bit_q;
      inh_d     = inh_q;
      tmo_d     = tmo_q;
      clk_oe_d  = clk_oe_q;
      data_oe_d = data_oe_q;
      err_d     = err_q;
      done_d    = 1'b0;
      ack_err_d = 1'b0;
      timeout_d = 1'b0;
      if (tmo_run)
         tmo_d = clk_fall ? '0 : (&tmo_q) ? tmo_q : tmo_q + 17'd1;
      // Timeout wins over a fall arriving in the same cycle.
      if (tmo_run && tmo_q == TMO_LAST) begin
         state_d   = IDLE;
         clk_oe_d  = 1'b0;
         data_oe_d = 1'b0;
         tmo_d     = '0;
         timeout_d = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               clk_oe_d  = 1'b0;
               data_oe_d = 1'b0;
               if (tx_valid) begin
                  frame_d  = ps2_frame(tx_data);
                  bit_d    = '0;
                  inh_d    = IW'(1);
                  tmo_d    = '0;
                  err_d    = 1'b0;
                  clk_oe_d = 1'b1;
                  state_d  = INHIBIT;
               end
            end
            INHIBIT: begin
               if (inh_q == INH_END) begin
                  clk_oe_d = 1'b0;
                  tmo_d    = '0;
                  state_d  = REQ;
               end else begin
                  inh_d = inh_q + IW'(1);
                  if (inh_q == INH_LAST) data_oe_d = 1'b1;
               end
            end
            REQ, SHIFT: begin
               if (clk_fall) begin
                  data_oe_d = ~frame_q[0];
                  frame_d   = {1'b1, frame_q[FRAME_BITS-1:1]};
                  bit_d     = bit_inc;
                  state_d   = (bit_q == 4'd9) ? ACK : SHIFT;
               end
            end
            ACK: begin
               data_oe_d = 1'b0;
               if (clk_fall) begin
                  bit_d     = bit_inc;
                  ack_err_d = data_lvl;
                  err_d     = data_lvl;
                  state_d   = RELEASE;
               end
            end
            RELEASE: begin
               clk_oe_d  = 1'b0;
               data_oe_d = 1'b0;
               if (clk_lvl && data_lvl) begin
                  done_d  = ~err_q;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
      ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         frame_q   <= '1;
         bit_q     <= '0;
         inh_q     <= '0;
         tmo_q     <= '0;
         clk_oe_q  <= 1'b0;
         data_oe_q <= 1'b0;
         ready_q   <= 1'b1;
         err_q     <= 1'b0;
         done_q    <= 1'b0;
         ack_err_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         frame_q   <= frame_d;
         bit_q     <= bit_d;
         inh_q     <= inh_d;
         tmo_q     <= tmo_d;
         clk_oe_q  <= clk_oe_d;
         data_oe_q <= data_oe_d;
         ready_q   <= ready_d;
         err_q     <= err_d;
         done_q    <= done_d;
         ack_err_q <= ack_err_d;
         timeout_q <= timeout_d;
      end
   end

   assign ps2_clk_oe  = clk_oe_q;
   assign ps2_data_oe = data_oe_q;
   assign tx_ready    = ready_q;
   assign busy        = ~ready_q;
   assign done        = done_q;
   assign ack_err     = ack_err_q;
   assign timeout     = timeout_q;

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: the outbound counterpart of ps2_kbd. Sends command bytes to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable.
- Sits beside ps2_kbd on cpu_clk (5 MHz). Drives PS2_CLK/PS2_DATA open-drain through board-level tristates: oe=1 pulls the line low, oe=0 releases it.
- busy gates ps2_kbd so it ignores bus activity while the host transmits.

Parameters:
- INHIBIT_CYCLES, 600, clk cycles ps2_clk is held low before the request (120 us at 5 MHz).
- TIMEOUT_CYCLES, 75000, maximum clk cycles between consecutive device clock falls while a transfer is in progress (15 ms).
- FILTER_LEN, 4, consecutive equal synchronized samples needed before a line level is accepted.

Ports:
- clk  in  1  system clock; cpu_clk in the board top.
- rst  in  1  asynchronous, active-low reset.
- ps2_clk_in  in  1  raw PS2_CLK pad level.
- ps2_data_in  in  1  raw PS2_DATA pad level.
- ps2_clk_oe  out  1  1 = pull PS2_CLK low.
- ps2_data_oe  out  1  1 = pull PS2_DATA low.
- tx_data  in  8  byte to send.
- tx_valid  in  1  request; byte accepted when tx_valid & tx_ready.
- tx_ready  out  1  high only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; device acknowledged the byte.
- ack_err  out  1  one-cycle pulse; no ack bit (data line high at ack slot).
- timeout  out  1  one-cycle pulse; transfer aborted on timeout.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; ps2_clk_oe=0, ps2_data_oe=0, tx_ready=1, busy=0, done=0, ack_err=0, timeout=0. Filters preset to 1 (bus idle high).
- Reset asserted mid-transfer releases both lines immediately. No pulse is produced.
- Input conditioning: 2-FF synchronizer, then a FILTER_LEN-sample filter per line.
  - fall = filtered clk was 1 last cycle and is 0 now.
  - Input-to-fall latency is at most 2+FILTER_LEN cycles.
- Shift register: 10-bit frame = {stop=1, parity=~^tx_data, tx_data[7:0]}, loaded on accept. Parity is odd.
- Bit counter: 4 bits, counts device falls 0..11.
- States and transitions:
  - IDLE: tx_ready=1. On tx_valid, latch the byte, clear the counters, go to INHIBIT next cycle. tx_valid outside IDLE is ignored; there is no queue.
  - INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles. In the last of those cycles, ps2_data_oe also rises (start bit). Then go to REQ.
  - REQ: ps2_clk_oe=0, ps2_data_oe=1. On the first fall go to SHIFT. That fall presents bit0: data_oe = ~frame[0].
  - SHIFT: each fall shifts out the next frame bit.
    - Falls 1-8 present data bits 0..7; fall 9 presents parity; fall 10 presents stop (data_oe=0).
    - data_oe always equals ~current bit, updated on the cycle after the fall.
    - After fall 10 go to ACK.
  - ACK: on fall 11, sample the filtered data line.
    - 0: go to RELEASE.
    - 1: pulse ack_err, go to RELEASE.
  - RELEASE: wait until the filtered clk and data are both 1. Then pulse done (only when no ack_err was recorded) and go to IDLE.
  - ack_err and done are mutually exclusive per transfer.
- Timeout: the counter clears on entry to REQ and on every fall, and counts in REQ/SHIFT/ACK/RELEASE.
  - On reaching TIMEOUT_CYCLES: both oe=0 the same cycle, pulse timeout, go to IDLE.
  - Timeout has priority over a simultaneous fall.
- Arithmetic: counters saturate; nothing wraps inside a transfer. The timeout counter is 17 bits.
- Outputs are registered. The oe outputs must never glitch.
- ps2_clk_oe and ps2_data_oe are never both driven from a stale frame after returning to IDLE.

Decomposition:
- ps2_pkg holds:
  - state encoding: IDLE, INHIBIT, REQ, SHIFT, ACK, RELEASE.
  - command constants: CMD_SET_LEDS=8'hED, CMD_RESET=8'hFF, CMD_ENABLE=8'hF4, RESP_ACK=8'hFA.
  - FRAME_BITS=10.
- Sub-module ps2_line_filter (sync + filter + fall detect) is instanced twice here. ps2_kbd is to reuse it.

Test Plan:
- Send 0xED with a device model clocking at 12 kHz that acks: on the bus, start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1; done pulses once; ack_err=0; tx_ready returns to 1.
- INHIBIT timing: accept at cycle N -> ps2_clk_oe=1 from N+1 for exactly 600 cycles; ps2_data_oe rises at N+600; ps2_clk_oe falls at N+601.
- Send 0x00 with the device holding data high at the ack slot: parity bit 1, ack_err pulses once, done never pulses, IDLE after lines go high.
- Device stops clocking after fall 4 -> timeout pulses 75000 cycles after that fall; both oe=0; tx_ready=1.
- rst=0 during SHIFT bit 5 -> both oe=0 immediately (asynchronous). After release, a fresh 0xF4 transfer completes with done.
- 1-cycle glitch on ps2_clk_in with FILTER_LEN=4 -> no fall counted; frame continues correctly. tx_valid while busy -> ignored; the frame bytes on the bus are unchanged.
